// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, ExcCodes, SR/Cause bit positions.
// Latency: none; constants and pure helper functions only.
// Backpressure: not applicable.
package cp0_pkg;

    // CP0 register numbers as seen on the mfc0/mtc0 addr field
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // SR / Cause field positions
    localparam int SR_IE         = 0;
    localparam int SR_EXL        = 1;
    localparam int IP_LSB        = 8;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_BD      = 31;

    // Return address for the faulting instruction: back up over the branch
    // when the instruction sits in a delay slot, always word aligned.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        logic [31:0] a;
        a = bd ? (pc - 32'd4) : pc;
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/irq_pending.sv
// One interrupt pending bit: level follower or rising-edge sticky latch.
// Latency: irq (or its rising edge) appears on ip one clock later.
// Backpressure: none; a software write of 0 clears a sticky bit, a same-cycle edge wins.
module irq_pending #(
    parameter bit EDGE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic wr,
    input  logic wr_val,
    output logic ip
);

    logic irq_q;

    // Edge history and pending state; new edges override a concurrent clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= 1'b0;
            ip    <= 1'b0;
        end else begin
            irq_q <= irq;
            if (EDGE)
                ip <= (irq & ~irq_q) | (wr ? wr_val : ip);
            else
                ip <= irq;
        end
    end

endmodule

// File: rtl/cp0_intc.sv
// CP0 interrupt/exception controller beside the M stage: SR/Cause/EPC/PRId, take and eret.
// Latency: take is combinational on registered IP/SR and exc_req; state updates at the next edge.
// Backpressure: none; take flushes M, so a concurrent mtc0 or eret is dropped. Option: CP0_TIMER_EN.
module cp0_intc
    import cp0_pkg::*;
#(
    parameter int                 NUM_IRQ   = 6,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
    parameter logic [31:0]        PRID      = 32'h0000_7001
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               exc_req,
    input  logic [4:0]         exc_code,
    input  logic [31:0]        pc_m,
    input  logic               bd_m,
    input  logic               we,
    input  logic [4:0]         addr,
    input  logic [31:0]        wdata,
    input  logic               eret,
    output logic [31:0]        rdata,
    output logic               take,
    output logic [31:0]        epc
);

    localparam int IP_MSB = IP_LSB + NUM_IRQ - 1;

    logic [NUM_IRQ-1:0] im;
    logic [NUM_IRQ-1:0] ip_line;
    logic [NUM_IRQ-1:0] ip;
    logic               ie;
    logic               exl;
    logic               bd;
    logic [4:0]         exc;
    logic [31:0]        epc_q;
    logic               int_p;
    logic               wr_ok;
    logic               wr_cause;

    // A flushed instruction must not commit its mtc0
    assign wr_ok    = we & ~take;
    assign wr_cause = wr_ok & (addr == CP0_CAUSE);

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
        irq_pending #(.EDGE(EDGE_MASK[g])) u_pend (
            .clk    (clk),
            .reset  (reset),
            .irq    (irq[g]),
            .wr     (wr_cause),
            .wr_val (wdata[IP_LSB + g]),
            .ip     (ip_line[g])
        );
    end

`ifdef CP0_TIMER_EN
    logic [31:0]        count;
    logic [31:0]        compare;
    logic               armed;
    logic               tpend;
    logic [NUM_IRQ-1:0] tmask;

    // Free-running counter and sticky compare match; match is disarmed until Compare is first written
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            compare <= '0;
            armed   <= 1'b0;
            tpend   <= 1'b0;
        end else begin
            count <= (wr_ok && addr == CP0_COUNT) ? wdata : count + 32'd1;
            if (wr_ok && addr == CP0_COMPARE) begin
                compare <= wdata;
                armed   <= 1'b1;
                tpend   <= 1'b0;
            end else if (armed && count == compare) begin
                tpend <= 1'b1;
            end
        end
    end

    // Timer pending rides on the highest interrupt line
    always_comb begin
        tmask              = '0;
        tmask[NUM_IRQ - 1] = tpend;
    end

    assign ip = ip_line | tmask;
`else
    assign ip = ip_line;
`endif

    assign int_p = (|(ip & im)) & ie & ~exl;
    assign take  = int_p | (exc_req & ~exl);
    assign epc   = epc_q;

    // Exception entry has priority over eret and mtc0 of the same instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im    <= '0;
            ie    <= 1'b0;
            exl   <= 1'b0;
            bd    <= 1'b0;
            exc   <= '0;
            epc_q <= '0;
        end else if (take) begin
            exl   <= 1'b1;
            bd    <= bd_m;
            epc_q <= epc_of(pc_m, bd_m);
            exc   <= int_p ? EXC_INT : exc_code;
        end else if (eret) begin
            exl <= 1'b0;
        end else if (we) begin
            if (addr == CP0_SR) begin
                im  <= wdata[IP_MSB:IP_LSB];
                exl <= wdata[SR_EXL];
                ie  <= wdata[SR_IE];
            end else if (addr == CP0_EPC) begin
                epc_q <= wdata;
            end
        end
    end

    // mfc0 read mux; unmapped registers read zero
    always_comb begin
        rdata = '0;
        case (addr)
            CP0_SR: begin
                rdata[IP_MSB:IP_LSB] = im;
                rdata[SR_EXL]        = exl;
                rdata[SR_IE]         = ie;
            end
            CP0_CAUSE: begin
                rdata[CAUSE_BD]                          = bd;
                rdata[IP_MSB:IP_LSB]                     = ip;
                rdata[CAUSE_EXC_LSB+4:CAUSE_EXC_LSB]     = exc;
            end
            CP0_EPC:  rdata = epc_q;
            CP0_PRID: rdata = PRID;
`ifdef CP0_TIMER_EN
            CP0_COUNT:   rdata = count;
            CP0_COMPARE: rdata = compare;
`endif
            default: rdata = '0;
        endcase
    end

endmodule

// File: doc/cp0_intc.md
Name: cp0_intc

Overview:
- Parametrised coprocessor-0 interrupt/exception controller for the pipelined MIPS core.
- Generalises the fixed 6-line HWInt[7:2]/ExcCode scheme:
  - NUM_IRQ lines, each selectable as level- or edge-sensitive.
  - SR/Cause/EPC/PRId registers accessed by mfc0/mtc0.
  - eret handling.
- Sits beside the M stage. The datapath feeds it the M-stage PC, exception requests and CP0 accesses; it returns the take/flush decision and EPC.

Parameters:
- NUM_IRQ, 6, number of hardware interrupt lines (1..8); they map to Cause/SR bits [8+NUM_IRQ-1:8].
- EDGE_MASK, 0, per-line bitmask; 1 = rising-edge sensitive with sticky pending, 0 = level.
- PRID, 32'h0000_7001, reset/constant value of PRId.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- irq  in  NUM_IRQ  hardware interrupt lines from the bridge
- exc_req  in  1  synchronous exception present on M-stage instruction
- exc_code  in  5  ExcCode of that exception
- pc_m  in  32  PC of M-stage instruction
- bd_m  in  1  M-stage instruction is in a delay slot
- we  in  1  mtc0 write strobe
- addr  in  5  CP0 register number (9,11,12,13,14,15)
- wdata  in  32  mtc0 data
- eret  in  1  eret in M stage
- rdata  out  32  mfc0 read data, combinational on addr
- take  out  1  exception/interrupt entered this cycle; flush pipeline, redirect to handler
- epc  out  32  current EPC, for eret redirect

Behaviour:
- Reset (reset=0, async):
  - SR = 0 (IE=0, EXL=0, IM=0).
  - Cause = 0. EPC = 0. Edge-detect history = 0.
  - take = 0 and rdata reads 0 for every register except PRId.
- SR layout: IM at [8+NUM_IRQ-1:8], EXL at [1], IE at [0]. Other bits read 0 and ignore writes.
- Cause layout: BD at [31], IP at [8+NUM_IRQ-1:8], ExcCode at [6:2]. Only IP bits of edge lines are software-writable; writing 0 clears a sticky pending bit.
- IP update, every clock:
  - Level line: IP[i] <= irq[i].
  - Edge line: IP[i] <= 1 on irq[i] rising (irq & ~irq_q). It holds until an mtc0 Cause write clears it. A new edge in the same cycle as the clear wins (stays 1).
- Interrupt pending (combinational): int_p = |(IP & IM) & IE & ~EXL.
- take = int_p | (exc_req & ~EXL).
  - Latency: an irq edge registers into IP at edge N, so take can assert in cycle N+1.
- On take (registered at next edge):
  - EXL <= 1.
  - BD <= bd_m.
  - EPC <= bd_m ? pc_m-4 : pc_m, with bits [1:0] forced to 0.
  - ExcCode <= 0 if int_p, else exc_code. An interrupt has priority over a simultaneous exception.
- eret with take=0: EXL <= 0 at next edge. eret with take=1: the eret is ignored.
- mtc0 (we=1, take=0): writes the register at addr.
  - Writes to PRId and unknown addresses are discarded.
  - With take=1 the write is suppressed, because the instruction is flushed.
- Exceptions while EXL=1 are not taken (no nesting). IP keeps updating.
- rdata: combinational mux on addr. Unmapped addresses read 0. IP reads the current registered pending state.

Optional Feature:
- CP0_TIMER_EN defined: adds Count (reg 9) and Compare (reg 11).
  - Count increments every clock and wraps at 2^32.
  - Count == Compare sets a sticky timer pending bit, ORed into IP[8+NUM_IRQ-1] (the highest line).
  - An mtc0 write to Compare clears the timer pending bit.
  - Both registers reset to 0. The compare match is ignored while Compare == 0 after reset, until the first write.
- CP0_TIMER_EN undefined: regs 9/11 read 0, writes are ignored, and no timer logic is built.

Decomposition:
- Shared package cp0_pkg:
  - Register number constants: CP0_COUNT=9, CP0_COMPARE=11, CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15.
  - ExcCode constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12.
  - SR/Cause bit-position constants.
- Sub-module irq_pending (one per line, generate): the level/edge latch with sticky clear. This is the natural split; the register file and take logic stay in cp0_intc.

Test Plan:
- Level IRQ: SR=0x0000_0401 (IM[10], IE); raise irq[2] -> take=1 one cycle after IP sets; Cause.ExcCode=0, IP[10]=1, EXL=1; EPC=pc_m (0x0000_3010).
- Edge IRQ, EDGE_MASK=6'b000001: pulse irq[0] for 1 cycle with IE=0 -> Cause IP[8] stays 1. Set IE -> take. mtc0 Cause=0 -> IP[8]=0.
- Delay slot: exc_req=1, exc_code=12, bd_m=1, pc_m=0x3020 -> EPC=0x301C, Cause=0x8000_0030, take=1.
- Simultaneous: int_p and exc_req (code 10) in the same cycle -> ExcCode=0. Also eret+take -> EXL stays 1. A concurrent mtc0 EPC write is discarded.
- Reset mid-handler: EXL=1, EPC=0x3040, assert reset low asynchronously -> SR/Cause/EPC read 0 immediately; PRId reads PRID.
- CP0_TIMER_EN: Compare=5 -> IP[13] (NUM_IRQ=6) sets when Count reaches 5. mtc0 Compare clears it.
